vote_tally: RTL
===============

Name: vote_tally

Overview:
- Multi-candidate vote accumulator; next-generation replacement for the single up-counter in the Voting System.
- Holds one saturating counter per candidate plus a total and a rejected-vote counter.
- Gates counting with a poll open/close state machine and reports the registered leader and tie status.
- Sits between the ballot-input debouncer/encoder and the display/result logic.

Parameters:
- NUM_CAND, 4, number of candidates (2..16).
- SEL_W, 2, width of the candidate select; 2**SEL_W >= NUM_CAND is required.
- CNT_W, 21, width of each candidate counter, the total counter and the reject counter.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- open_poll  in  1  pulse; starts a poll.
- close_poll  in  1  pulse; ends a poll.
- clear  in  1  pulse; zeroes all tallies.
- vote_valid  in  1  one vote presented this cycle.
- vote_sel  in  SEL_W  candidate index for the vote.
- counts  out  NUM_CAND*CNT_W  flattened counters; candidate i occupies bits [i*CNT_W +: CNT_W].
- total  out  CNT_W  accepted votes.
- rejected  out  CNT_W  votes dropped (bad index or saturated).
- leader  out  SEL_W  index of the highest count.
- tie  out  1  two or more candidates share the highest count, and that count is > 0.
- poll_state  out  2  00 IDLE, 01 OPEN, 10 CLOSED.
- sat  out  1  sticky; some candidate counter reached all-ones.

Behaviour:
- Reset (rst=1 at a clk edge): FSM goes to IDLE. counts, total, rejected, leader, tie and sat all become 0. rst overrides every other input.
- FSM transitions:
  - IDLE: open_poll -> OPEN.
  - OPEN: close_poll -> CLOSED. open_poll and clear are ignored.
  - CLOSED: open_poll -> OPEN (tallies kept; resumes the poll). clear -> IDLE with all tallies and sat zeroed.
  - IDLE: clear zeroes tallies and stays in IDLE.
  - If open_poll and close_poll are both high in OPEN, close wins. If open_poll and clear are both high in CLOSED, clear wins.
- A vote is sampled only when vote_valid=1 and the FSM is OPEN at the clk edge.
  - A vote arriving in the same cycle as close_poll is still counted.
  - A vote arriving in the same cycle as the open_poll that causes IDLE->OPEN is not counted.
- Accepted vote (vote_sel < NUM_CAND and counts[vote_sel] != all-ones):
  - counts[vote_sel] and total each increment by 1, visible the cycle after the edge (latency 1).
  - total also saturates at all-ones.
- Rejected vote (vote_sel >= NUM_CAND, or the target counter is saturated):
  - no candidate or total change.
  - rejected increments (saturating).
  - a saturated-target reject also sets sat=1.
- At most one vote per cycle; no back-pressure.
- Votes presented while the FSM is not OPEN are ignored: no counter changes, not counted as rejected.
- leader and tie are registered from the current counts, so they update one cycle after counts (latency 2 from the vote edge).
  - leader is the lowest index among the maxima.
  - All counts zero: leader=0, tie=0.
- Counts, leader and tie are all held while the FSM is CLOSED.
- rst asserted mid-poll discards all tallies immediately.

Test Plan:
- Reset, open_poll, votes to candidates 0,1,1,2,1 on consecutive cycles, then close_poll -> counts={c0=1,c1=3,c2=1,c3=0}, total=5, leader=1, tie=0, poll_state=10.
- Open, 2 votes to c2 and 2 votes to c3 -> tie=1, leader=2. One further c3 vote -> tie=0, leader=3 two cycles later.
- NUM_CAND=3 build: vote_sel=3 while OPEN -> rejected=1, total unchanged. vote_valid while IDLE -> no change at all.
- CNT_W=4 build: 16 votes to c0 -> c0=15, 16th vote rejected, sat=1, total=15.
- vote_valid with close_poll in the same cycle -> vote counted. Then clear from CLOSED -> every output 0, poll_state=00. Reopen, then assert rst mid-poll after 3 votes -> all outputs 0 next cycle.
- open_poll and close_poll together in OPEN -> CLOSED. open_poll and clear together in CLOSED -> IDLE with zeroed tallies.

Source files
------------

// File: rtl/vote_tally.sv
`default_nettype none
//==============================================================================
// Module   : vote_tally
// Brief    : Multi-candidate saturating vote accumulator gated by a poll FSM,
//            with registered leader/tie reporting.
// Revision : 1.0 - initial release
//==============================================================================
module vote_tally #(
    parameter int NUM_CAND = 4,
    parameter int SEL_W    = 2,
    parameter int CNT_W    = 21
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      open_poll,
    input  logic                      close_poll,
    input  logic                      clear,
    input  logic                      vote_valid,
    input  logic [SEL_W-1:0]          vote_sel,
    output logic [NUM_CAND*CNT_W-1:0] counts,
    output logic [CNT_W-1:0]          total,
    output logic [CNT_W-1:0]          rejected,
    output logic [SEL_W-1:0]          leader,
    output logic                      tie,
    output logic [1:0]                poll_state,
    output logic                      sat
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_OPEN   = 2'b01,
        S_CLOSED = 2'b10
    } state_t;

    localparam logic [CNT_W-1:0] c_max    = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] c_almost = c_max - 1'b1;
    localparam logic [SEL_W:0]   c_num    = (SEL_W+1)'(NUM_CAND);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt [NUM_CAND];
    logic [CNT_W-1:0] r_total;
    logic [CNT_W-1:0] r_rej;
    logic [SEL_W-1:0] r_leader;
    logic             r_tie;
    logic             r_sat;

    logic             w_vote;
    logic             w_in_range;
    logic             w_target_full;
    logic             w_accept;
    logic             w_reject;
    logic             w_clear;
    logic [CNT_W-1:0] w_best;
    logic [SEL_W-1:0] w_lead;
    logic             w_tie;

    assign w_vote     = vote_valid && (r_state == S_OPEN);
    assign w_in_range = ({1'b0, vote_sel} < c_num);
    assign w_clear    = clear && (r_state != S_OPEN);

    // Out-of-range selects never match a candidate, so no array read overruns.
    always_comb begin
        w_target_full = 1'b0;
        for (int i = 0; i < NUM_CAND; i++) begin
            if (vote_sel == SEL_W'(i)) begin
                w_target_full = (r_cnt[i] == c_max);
            end
        end
    end

    assign w_accept = w_vote && w_in_range && !w_target_full;
    assign w_reject = w_vote && !w_accept;

    // Strict '>' keeps the lowest index among equal maxima.
    always_comb begin
        w_best = r_cnt[0];
        w_lead = '0;
        w_tie  = 1'b0;
        for (int i = 1; i < NUM_CAND; i++) begin
            if (r_cnt[i] > w_best) begin
                w_best = r_cnt[i];
                w_lead = SEL_W'(i);
            end
        end
        for (int i = 0; i < NUM_CAND; i++) begin
            if ((SEL_W'(i) != w_lead) && (r_cnt[i] == w_best) && (w_best != '0)) begin
                w_tie = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_total  <= '0;
            r_rej    <= '0;
            r_leader <= '0;
            r_tie    <= 1'b0;
            r_sat    <= 1'b0;
            for (int i = 0; i < NUM_CAND; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            case (r_state)
                S_IDLE:   if (open_poll) r_state <= S_OPEN;
                S_OPEN:   if (close_poll) r_state <= S_CLOSED;
                S_CLOSED: begin
                    if (clear)          r_state <= S_IDLE;
                    else if (open_poll) r_state <= S_OPEN;
                end
                default:  r_state <= S_IDLE;
            endcase

            if (w_clear) begin
                r_total  <= '0;
                r_rej    <= '0;
                r_leader <= '0;
                r_tie    <= 1'b0;
                r_sat    <= 1'b0;
                for (int i = 0; i < NUM_CAND; i++) begin
                    r_cnt[i] <= '0;
                end
            end else begin
                r_leader <= w_lead;
                r_tie    <= w_tie;
                if (w_accept) begin
                    for (int i = 0; i < NUM_CAND; i++) begin
                        if (vote_sel == SEL_W'(i)) begin
                            r_cnt[i] <= r_cnt[i] + 1'b1;
                            if (r_cnt[i] == c_almost) r_sat <= 1'b1;
                        end
                    end
                    if (r_total != c_max) r_total <= r_total + 1'b1;
                end
                if (w_reject) begin
                    if (r_rej != c_max) r_rej <= r_rej + 1'b1;
                    if (w_in_range)     r_sat <= 1'b1;
                end
            end
        end
    end

    generate
        for (genvar g = 0; g < NUM_CAND; g++) begin : g_pack
            assign counts[g*CNT_W +: CNT_W] = r_cnt[g];
        end
    endgenerate

    assign total      = r_total;
    assign rejected   = r_rej;
    assign leader     = r_leader;
    assign tie        = r_tie;
    assign poll_state = r_state;
    assign sat        = r_sat;

endmodule
`default_nettype wire
